// File: rtl/sha_blk_pkg.sv
// Shared SHA block-assembly definitions: word/block geometry and controller state encoding.
// No logic, no latency.
// No flow control; consumed by the block loader and its parent.
package sha_blk_pkg;

    localparam int BLK_WORD_W    = 32;
    localparam int BLK_NUM_WORDS = 13;
    localparam int BLK_BLOCK_W   = BLK_WORD_W * BLK_NUM_WORDS;
    localparam int BLK_CNT_W     = 4;

    typedef logic [BLK_CNT_W-1:0] cnt_t;

    // LOAD: collecting words; COMMIT: one-cycle write strobe; HOLD: block offered to hash core
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/block_load_ctrl_416.sv
// Assembles 13 x 32-bit words MSW-first into a 416-bit block, writes it once, then holds it for the hash core.
// Latency: block write strobe the cycle after the 13th accept; block_valid the cycle after that.
// Backpressure: word_ready low outside LOAD; block held until block_taken; abort discards at any point.
//
// Ports:
//   CLK, RST          clock, asynchronous active-low reset
//   word_in/_valid    word stream in; word_ready out (accept = valid & ready & !abort)
//   abort             drop partial or held block, return to LOAD
//   block_taken       hash core consumed the held block
//   mem_write_en      one-cycle write strobe to the parent's block memory
//   mem_block         assembled block (block memory data)
//   block_valid       committed block available
//   word_cnt          words accepted in current block (0..13)
module block_load_ctrl_416
    import sha_blk_pkg::*;
#(
    parameter int WORD_W    = BLK_WORD_W,
    parameter int NUM_WORDS = BLK_NUM_WORDS,
    parameter int BLOCK_W   = BLK_BLOCK_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WORD_W-1:0]    word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic                 abort,
    input  logic                 block_taken,
    output logic                 mem_write_en,
    output logic [BLOCK_W-1:0]   mem_block,
    output logic                 block_valid,
    output logic [BLK_CNT_W-1:0] word_cnt
);

    if (BLOCK_W != WORD_W * NUM_WORDS) begin : g_bad_geometry
        $error("block_load_ctrl_416: BLOCK_W must equal WORD_W*NUM_WORDS");
    end

    localparam cnt_t CNT_LAST = cnt_t'(NUM_WORDS - 1);

    state_e              state_q, state_d;
    cnt_t                cnt_q, cnt_d;
    logic [BLOCK_W-1:0]  blk_q, blk_d;
    logic                rdy_en_q;
    logic                accept;

    // Keeps word_ready low during reset and for the first edge after release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign word_ready   = (state_q == ST_LOAD) && rdy_en_q;
    assign accept       = word_valid && word_ready && !abort;
    assign mem_write_en = (state_q == ST_COMMIT);
    assign block_valid  = (state_q == ST_HOLD);
    assign mem_block    = blk_q;
    assign word_cnt     = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        if (abort) begin
            // Overrides everything; a write already strobing this cycle still completes
            // because mem_write_en decodes the current state only.
            state_d = ST_LOAD;
            cnt_d   = '0;
            blk_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        // First word of a new block wipes the previously committed image.
                        if (cnt_q == '0) begin
                            blk_d = '0;
                        end
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            if (cnt_q == cnt_t'(k)) begin
                                blk_d[BLOCK_W-1-WORD_W*k -: WORD_W] = word_in;
                            end
                        end
                        cnt_d = cnt_q + cnt_t'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (block_taken) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_block_load_ctrl_416.sv
module tb_block_load_ctrl_416;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic         abort;
    logic         block_taken;
    logic         mem_write_en;
    logic [415:0] mem_block;
    logic         block_valid;
    logic [3:0]   word_cnt;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0;
    int wen_mark;

    always #5 CLK = ~CLK;

    block_load_ctrl_416 dut (
        .CLK          (CLK),
        .RST          (RST),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .abort        (abort),
        .block_taken  (block_taken),
        .mem_write_en (mem_write_en),
        .mem_block    (mem_block),
        .block_valid  (block_valid),
        .word_cnt     (word_cnt)
    );

    // Write strobes observed mid-cycle.
    always @(negedge CLK) begin
        if (mem_write_en === 1'b1) wen_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic [31:0] w;
        logic        tkn;
        logic        e_rdy;
        logic        e_wen;
        logic        e_bv;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[28];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [415:0] act, input logic [415:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [415:0] exp_blk(input logic [31:0] base);
        logic [415:0] r;
        r = '0;
        for (int k = 0; k < 13; k++) r[415-32*k -: 32] = base + 32'(k);
        return r;
    endfunction

    task automatic load_blk(input string nm, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            word_in    = base + 32'(k);
            word_valid = 1'b1;
            tick();
            chk($sformatf("%s.cnt%0d", nm, k), word_cnt, 416'(k + 1));
            if (k < 12) chk($sformatf("%s.nowen%0d", nm, k), mem_write_en, 0);
        end
        word_valid = 1'b0;
    endtask

    task automatic chk_idle_reset(input string nm);
        chk({nm, ".rdy"}, word_ready, 0);
        chk({nm, ".wen"}, mem_write_en, 0);
        chk({nm, ".bv"},  block_valid, 0);
        chk({nm, ".cnt"}, word_cnt, 0);
        chk({nm, ".blk"}, mem_block, 0);
    endtask

    initial begin
        // Table: word_valid toggled every other cycle, then a word offered in HOLD, then release.
        for (int j = 0; j < 26; j++) begin
            tbl[j].vld   = (j % 2 == 0);
            tbl[j].w     = 32'h100 + 32'(j / 2);
            tbl[j].tkn   = 1'b0;
            tbl[j].e_cnt = 4'(j / 2 + 1);
            tbl[j].e_rdy = (j < 24);
            tbl[j].e_wen = (j == 24);
            tbl[j].e_bv  = (j == 25);
        end
        tbl[26] = '{vld: 1'b1, w: 32'hDEAD_BEEF, tkn: 1'b0, e_rdy: 1'b0, e_wen: 1'b0, e_bv: 1'b1, e_cnt: 4'd13};
        tbl[27] = '{vld: 1'b0, w: 32'h0,         tkn: 1'b1, e_rdy: 1'b1, e_wen: 1'b0, e_bv: 1'b0, e_cnt: 4'd0};

        RST = 1'b0; word_in = '0; word_valid = 1'b0; abort = 1'b0; block_taken = 1'b0;
        tick(); tick();
        chk_idle_reset("reset");
        RST = 1'b1;
        #1;
        chk("rst_rel.rdy_not_yet", word_ready, 0);
        tick();
        chk("rst_rel.rdy", word_ready, 1);

        // 13 back-to-back words 1..13
        wen_mark = wen_cnt;
        load_blk("b2b", 32'h1, 13);
        chk("b2b.wen14", mem_write_en, 1);
        chk("b2b.rdy_commit", word_ready, 0);
        chk("b2b.msw", mem_block[415:384], 32'h1);
        chk("b2b.lsw", mem_block[31:0], 32'hD);
        chk("b2b.blk", mem_block, exp_blk(32'h1));
        tick();
        chk("b2b.wen15", mem_write_en, 0);
        chk("b2b.bv15", block_valid, 1);
        chk("b2b.cnt_hold", word_cnt, 13);
        tick(); tick();
        chk("b2b.bv_held", block_valid, 1);
        chk("b2b.cnt_nowrap", word_cnt, 13);
        block_taken = 1'b1;
        tick();
        block_taken = 1'b0;
        chk("b2b.rel.rdy", word_ready, 1);
        chk("b2b.rel.cnt", word_cnt, 0);
        chk("b2b.rel.bv", block_valid, 0);
        chk("b2b.rel.blk_held", mem_block, exp_blk(32'h1));
        chk("b2b.strobes", 416'(wen_cnt - wen_mark), 1);

        // Table-driven toggled-valid sequence
        wen_mark = wen_cnt;
        for (int i = 0; i < 28; i++) begin
            word_valid  = tbl[i].vld;
            word_in     = tbl[i].w;
            block_taken = tbl[i].tkn;
            tick();
            chk($sformatf("vec%0d.rdy", i), word_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d.wen", i), mem_write_en, tbl[i].e_wen);
            chk($sformatf("vec%0d.bv", i), block_valid, tbl[i].e_bv);
            chk($sformatf("vec%0d.cnt", i), word_cnt, tbl[i].e_cnt);
        end
        word_valid = 1'b0; block_taken = 1'b0;
        chk("vec.strobes", 416'(wen_cnt - wen_mark), 1);
        chk("vec.blk", mem_block, exp_blk(32'h100));

        // block_taken held through LOAD and COMMIT, then pulsed after 5 idle HOLD cycles
        block_taken = 1'b1;
        load_blk("tkn", 32'h200, 13);
        chk("tkn.wen", mem_write_en, 1);
        tick();
        block_taken = 1'b0;
        chk("tkn.bv", block_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("tkn.idle%0d.bv", i), block_valid, 1);
            chk($sformatf("tkn.idle%0d.rdy", i), word_ready, 0);
        end
        block_taken = 1'b1;
        tick();
        block_taken = 1'b0;
        chk("tkn.rel.rdy", word_ready, 1);
        chk("tkn.rel.cnt", word_cnt, 0);

        // Abort after 7 words, with a word presented alongside the abort
        wen_mark = wen_cnt;
        load_blk("abt", 32'hA0, 7);
        word_valid = 1'b1; word_in = 32'hEE; abort = 1'b1;
        tick();
        abort = 1'b0; word_valid = 1'b0;
        chk("abt.cnt", word_cnt, 0);
        chk("abt.blk", mem_block, 0);
        chk("abt.rdy", word_ready, 1);
        chk("abt.nostrobe", 416'(wen_cnt - wen_mark), 0);
        load_blk("abt2", 32'hB0, 13);
        chk("abt2.wen", mem_write_en, 1);
        chk("abt2.blk", mem_block, exp_blk(32'hB0));
        tick();
        chk("abt2.strobes", 416'(wen_cnt - wen_mark), 1);
        block_taken = 1'b1;
        tick();
        block_taken = 1'b0;

        // Abort sampled in the COMMIT cycle
        wen_mark = wen_cnt;
        load_blk("cab", 32'hC0, 13);
        abort = 1'b1;
        #1;
        chk("cab.wen_with_abort", mem_write_en, 1);
        tick();
        abort = 1'b0;
        chk("cab.rdy", word_ready, 1);
        chk("cab.cnt", word_cnt, 0);
        chk("cab.blk", mem_block, 0);
        chk("cab.bv", block_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("cab.bv%0d", i), block_valid, 0);
        end
        chk("cab.strobes", 416'(wen_cnt - wen_mark), 1);

        // Reset mid-LOAD at word_cnt=9, then in HOLD
        wen_mark = wen_cnt;
        load_blk("rl", 32'hD0, 9);
        chk("rl.cnt9", word_cnt, 9);
        RST = 1'b0;
        #1;
        chk_idle_reset("rl.async");
        tick();
        chk_idle_reset("rl.held");
        RST = 1'b1;
        tick();
        chk("rl.rdy", word_ready, 1);
        load_blk("rh", 32'hE0, 13);
        tick();
        chk("rh.bv", block_valid, 1);
        RST = 1'b0;
        #1;
        chk_idle_reset("rh.async");
        tick(); tick();
        chk_idle_reset("rh.held");
        RST = 1'b1;
        tick();
        chk("rh.rdy", word_ready, 1);
        chk("rh.cnt", word_cnt, 0);
        tick();
        chk("rh.bv_after", block_valid, 0);
        chk("rst.strobes", 416'(wen_cnt - wen_mark), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
